// File: rtl/io_pkg.sv
// Shared board I/O definitions for the 8-to-1 bit-select path (transmit select
// counter and receive-side collector).
package io_pkg;

  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;

  typedef logic [IDX_W-1:0] bit_idx_t;

endpackage : io_pkg

// File: rtl/serial_to_parallel_8.sv
// Collects one serial bit per accepted cycle into an 8-bit word and hands each
// completed word off through a one-entry valid/ready holding register.
module serial_to_parallel_8
  import io_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sync,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output bit_idx_t          bit_idx,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam bit_idx_t LAST_IDX = bit_idx_t'(WORD_W - 1);

  logic [WORD_W-1:0] r_partial;
  logic [WORD_W-1:0] r_word;
  bit_idx_t          r_idx;
  logic              r_valid;
  logic              r_overrun;

  bit_idx_t          w_cur_idx;
  bit_idx_t          w_pos;
  logic [WORD_W-1:0] w_base;
  logic [WORD_W-1:0] w_merged;
  logic              w_complete;
  logic              w_drain;
  logic              w_drop;

  // A sync restarts the frame, so the bit arriving with it is index 0 of an
  // empty word; it can therefore never complete a word on the same cycle.
  assign w_cur_idx  = sync ? '0 : r_idx;
  assign w_base     = sync ? '0 : r_partial;
  assign w_pos      = LSB_FIRST ? w_cur_idx : (LAST_IDX - w_cur_idx);
  assign w_complete = bit_valid && (w_cur_idx == LAST_IDX);
  assign w_drain    = r_valid && word_ready;
  assign w_drop     = w_complete && r_valid && !word_ready;

  always_comb begin
    w_merged        = w_base;
    w_merged[w_pos] = bit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_partial <= '0;
      r_idx     <= '0;
    end else if (bit_valid) begin
      r_partial <= w_complete ? '0 : w_merged;
      r_idx     <= w_cur_idx + bit_idx_t'(1);
    end else if (sync) begin
      r_partial <= '0;
      r_idx     <= '0;
    end
  end

  // Holding register: a completion refills it if it is empty or draining now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (w_complete && (!r_valid || word_ready)) begin
      r_word  <= w_merged;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign bit_idx    = r_idx;
  assign overrun    = r_overrun;

endmodule : serial_to_parallel_8
